cmp_arbiter: RTL and testbench

CMP_ARBITER -- requirements
Module: cmp_arbiter

---
 rtl/cmp_arbiter_if.sv | 33 +++
 rtl/cmp_arbiter.sv | 124 ++++++++++++
 tb/tb_cmp_arbiter.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/cmp_arbiter_if.sv
// Bundle of the requester handshakes and the shared comparator hookup for cmp_arbiter.
interface cmp_arbiter_if #(
  parameter int unsigned WIDTH = 18
);
  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             done0;
  logic             done1;
  logic             zf_out;
  logic             cf_out;
  logic             busy;
  logic [WIDTH-1:0] cmp_a;
  logic [WIDTH-1:0] cmp_b;
  logic             cmp_en;
  logic             cmp_zf;
  logic             cmp_cf;

  // Arbiter side
  modport slave (
    input  req0, req1, a0, b0, a1, b1, cmp_zf, cmp_cf,
    output done0, done1, zf_out, cf_out, busy, cmp_a, cmp_b, cmp_en
  );

  // Requesters plus comparator side
  modport master (
    output req0, req1, a0, b0, a1, b1, cmp_zf, cmp_cf,
    input  done0, done1, zf_out, cf_out, busy, cmp_a, cmp_b, cmp_en
  );
endinterface

// File: rtl/cmp_arbiter.sv
// Two-requester round-robin front end for a single shared comparator.
// One compare takes IDLE -> ISSUE -> CAPTURE -> RESP; done pulses in RESP.
module cmp_arbiter #(
  parameter int unsigned WIDTH = 18
) (
  input  logic         clk,
  input  logic         clear,
  cmp_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             grant_q, grant_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] cmp_a_q, cmp_a_d;
  logic [WIDTH-1:0] cmp_b_q, cmp_b_d;
  logic             cmp_en_q, cmp_en_d;
  logic             done0_q, done0_d;
  logic             done1_q, done1_d;
  logic             zf_q, zf_d;
  logic             cf_q, cf_d;
  logic             busy_q, busy_d;
  logic             pick_c;

  // Tie goes to whoever was not served last; otherwise the lone requester wins.
  always_comb begin
    if (bus.req0 && bus.req1) begin
      pick_c = ~last_q;
    end else begin
      pick_c = bus.req1;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    cmp_a_d  = cmp_a_q;
    cmp_b_d  = cmp_b_q;
    zf_d     = zf_q;
    cf_d     = cf_q;
    cmp_en_d = 1'b0;
    done0_d  = 1'b0;
    done1_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          state_d  = ISSUE;
          grant_d  = pick_c;
          cmp_a_d  = pick_c ? bus.a1 : bus.a0;
          cmp_b_d  = pick_c ? bus.b1 : bus.b0;
          cmp_en_d = 1'b1;
        end
      end
      ISSUE: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        // Flags are valid now: the comparator sampled on the ISSUE edge.
        state_d = RESP;
        zf_d    = bus.cmp_zf;
        cf_d    = bus.cmp_cf;
        done0_d = ~grant_q;
        done1_d = grant_q;
      end
      RESP: begin
        state_d = IDLE;
        last_d  = grant_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q  <= IDLE;
      grant_q  <= 1'b0;
      last_q   <= 1'b1;
      cmp_a_q  <= '0;
      cmp_b_q  <= '0;
      cmp_en_q <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      zf_q     <= 1'b0;
      cf_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      cmp_a_q  <= cmp_a_d;
      cmp_b_q  <= cmp_b_d;
      cmp_en_q <= cmp_en_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      zf_q     <= zf_d;
      cf_q     <= cf_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.cmp_a  = cmp_a_q;
  assign bus.cmp_b  = cmp_b_q;
  assign bus.cmp_en = cmp_en_q;
  assign bus.done0  = done0_q;
  assign bus.done1  = done1_q;
  assign bus.zf_out = zf_q;
  assign bus.cf_out = cf_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Directed bench for cmp_arbiter: vector table of single requests plus
// hand-written contention, operand-freeze and mid-operation clear sequences.
module tb_cmp_arbiter;

  localparam int unsigned W = 18;

  logic clk;
  logic clear;
  int   checks;
  int   failures;

  cmp_arbiter_if #(.WIDTH(W)) bus ();

  cmp_arbiter #(.WIDTH(W)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference comparator: samples on the cmp_en edge, flags valid next cycle.
  always_ff @(posedge clk) begin
    if (clear) begin
      bus.cmp_zf <= 1'b0;
      bus.cmp_cf <= 1'b0;
    end else if (bus.cmp_en) begin
      bus.cmp_zf <= (bus.cmp_a == bus.cmp_b);
      bus.cmp_cf <= (bus.cmp_a <  bus.cmp_b);
    end
  end

  typedef struct {
    string      name;
    logic       r0;
    logic       r1;
    logic [W-1:0] a0;
    logic [W-1:0] b0;
    logic [W-1:0] a1;
    logic [W-1:0] b1;
    int         exp_idx;
    logic       ezf;
    logic       ecf;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // One request from IDLE; optionally rewrites a0 while the op is in flight.
  task automatic run_one(input string name, input logic r0, input logic r1,
                         input int exp_idx, input logic ezf, input logic ecf,
                         input logic [W-1:0] exp_a, input logic [W-1:0] exp_b,
                         input logic mod_a0, input logic [W-1:0] mod_val);
    int   en_cnt   = 0;
    int   en_k     = -1;
    int   done_k   = -1;
    int   done_idx = -1;
    int   both     = 0;
    logic got_zf   = 1'bx;
    logic got_cf   = 1'bx;
    logic [W-1:0] a_k1 = 'x;
    logic [W-1:0] a_done = 'x;
    logic [W-1:0] b_done = 'x;
    bus.req0 = r0;
    bus.req1 = r1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.cmp_en) begin
        en_cnt++;
        if (en_k < 0) en_k = k;
      end
      if (k == 1) a_k1 = bus.cmp_a;
      if (bus.done0 && bus.done1) both++;
      if ((bus.done0 || bus.done1) && done_k < 0) begin
        done_k   = k;
        done_idx = bus.done1 ? 1 : 0;
        got_zf   = bus.zf_out;
        got_cf   = bus.cf_out;
        a_done   = bus.cmp_a;
        b_done   = bus.cmp_b;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
      end
      if (k == 1 && mod_a0) bus.a0 = mod_val;
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    chk({name, ".en_cnt"},   32'(en_cnt),   32'd1);
    chk({name, ".en_cycle"}, 32'(en_k),     32'd1);
    chk({name, ".latency"},  32'(done_k),   32'd3);
    chk({name, ".done_idx"}, 32'(done_idx), 32'(exp_idx));
    chk({name, ".both"},     32'(both),     32'd0);
    chk({name, ".zf"},       32'(got_zf),   32'(ezf));
    chk({name, ".cf"},       32'(got_cf),   32'(ecf));
    chk({name, ".cmp_a"},    32'(a_k1),     32'(exp_a));
    chk({name, ".cmp_a_held"}, 32'(a_done), 32'(exp_a));
    chk({name, ".cmp_b_held"}, 32'(b_done), 32'(exp_b));
    chk({name, ".idle"},     32'(bus.busy), 32'd0);
  endtask

  task automatic chk_reset_state(input string name);
    chk({name, ".busy"},   32'(bus.busy),   32'd0);
    chk({name, ".cmp_en"}, 32'(bus.cmp_en), 32'd0);
    chk({name, ".done0"},  32'(bus.done0),  32'd0);
    chk({name, ".done1"},  32'(bus.done1),  32'd0);
    chk({name, ".zf"},     32'(bus.zf_out), 32'd0);
    chk({name, ".cf"},     32'(bus.cf_out), 32'd0);
    chk({name, ".cmp_a"},  32'(bus.cmp_a),  32'd0);
    chk({name, ".cmp_b"},  32'(bus.cmp_b),  32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   d_k [4];
    int   d_i [4];
    logic d_z [4];
    logic d_c [4];
    int   nd;
    logic [1:0] exp_zc [2];

    checks   = 0;
    failures = 0;
    clear    = 1'b1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.a0   = '0;
    bus.b0   = '0;
    bus.a1   = '0;
    bus.b1   = '0;

    vecs[0] = '{"single_gt",  1'b1, 1'b0, 18'h2AAAA, 18'h15555, 18'h0,     18'h0,     0, 1'b0, 1'b0};
    vecs[1] = '{"equal_r1",   1'b0, 1'b1, 18'h0,     18'h0,     18'h3FFFF, 18'h3FFFF, 1, 1'b1, 1'b0};
    vecs[2] = '{"less_r0",    1'b1, 1'b0, 18'h0,     18'h1,     18'h0,     18'h0,     0, 1'b0, 1'b1};
    vecs[3] = '{"gt_r1",      1'b0, 1'b1, 18'h0,     18'h0,     18'h003E8, 18'h00003, 1, 1'b0, 1'b0};
    vecs[4] = '{"zero_eq_r0", 1'b1, 1'b0, 18'h0,     18'h0,     18'h3FFFF, 18'h00001, 0, 1'b1, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_state("reset");
    clear = 1'b0;

    // Contention: both held from reset; requester 0 must win the first tie.
    bus.a0 = 18'd5; bus.b0 = 18'd9;
    bus.a1 = 18'd7; bus.b1 = 18'd7;
    exp_zc[0] = 2'b01;
    exp_zc[1] = 2'b10;
    for (int i = 0; i < 4; i++) begin
      d_k[i] = -1; d_i[i] = -1; d_z[i] = 1'bx; d_c[i] = 1'bx;
    end
    nd = 0;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("contend.not_both", 32'(bus.done0 & bus.done1), 32'd0);
      if ((bus.done0 || bus.done1) && nd < 4) begin
        d_k[nd] = k;
        d_i[nd] = bus.done1 ? 1 : 0;
        d_z[nd] = bus.zf_out;
        d_c[nd] = bus.cf_out;
        nd++;
        if (nd == 4) begin
          bus.req0 = 1'b0;
          bus.req1 = 1'b0;
        end
      end
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("contend[%0d].idx", i),   32'(d_i[i]), 32'(i % 2));
      chk($sformatf("contend[%0d].cycle", i), 32'(d_k[i]), 32'(3 + 4 * i));
      chk($sformatf("contend[%0d].zf", i),    32'(d_z[i]), 32'(exp_zc[i % 2][1]));
      chk($sformatf("contend[%0d].cf", i),    32'(d_c[i]), 32'(exp_zc[i % 2][0]));
    end

    // Single-request vector table
    for (int i = 0; i < 5; i++) begin
      bus.a0 = vecs[i].a0; bus.b0 = vecs[i].b0;
      bus.a1 = vecs[i].a1; bus.b1 = vecs[i].b1;
      run_one(vecs[i].name, vecs[i].r0, vecs[i].r1, vecs[i].exp_idx,
              vecs[i].ezf, vecs[i].ecf,
              vecs[i].exp_idx == 1 ? vecs[i].a1 : vecs[i].a0,
              vecs[i].exp_idx == 1 ? vecs[i].b1 : vecs[i].b0,
              1'b0, '0);
    end

    // Operand rewritten during ISSUE must not leak into the compare.
    bus.a0 = 18'd100; bus.b0 = 18'd200;
    run_one("freeze", 1'b1, 1'b0, 0, 1'b0, 1'b1, 18'd100, 18'd200, 1'b1, 18'd200);

    // Leave non-zero flags so the clear is observable.
    bus.a1 = 18'h1234; bus.b1 = 18'h1234;
    run_one("pre_clear", 1'b0, 1'b1, 1, 1'b1, 1'b0, 18'h1234, 18'h1234, 1'b0, '0);

    // Clear while in CAPTURE aborts without a done pulse.
    bus.a0 = 18'd3; bus.b0 = 18'd3;
    bus.req0 = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("abort.issue_en", 32'(bus.cmp_en), 32'd1);
    @(posedge clk); @(negedge clk);
    chk("abort.capture_busy", 32'(bus.busy), 32'd1);
    clear = 1'b1;
    bus.req0 = 1'b0;
    @(posedge clk); @(negedge clk);
    chk_reset_state("abort");
    clear = 1'b0;
    run_one("after_clear", 1'b1, 1'b0, 0, 1'b1, 1'b0, 18'd3, 18'd3, 1'b0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
